tap_read_arbiter: RTL
=====================

# tap_read_arbiter

Drives the read side of the TAP read interconnect and serialises the fetched word onto the UART transmit path. It accepts read commands from the UART command decoder, requests data from the addressed peripheral, and retries until data is valid or a retry limit is hit. It then emits the result as a little-endian byte frame to the UART TX.

## Interface
Parameters:
- READ_WIDTH, 41, width of the read data word from the interconnect.
- RETRY_LIMIT, 15, maximum re-requests after an invalid capture before a zero frame is sent.

Ports:
- CLK_I  in  1  clock; all logic is single-clock.
- RST_NI  in  1  reset, asynchronous and active-low.
- CMD_VALID_I  in  1  read command valid.
- CMD_READY_O  out  1  command accepted when high together with CMD_VALID_I.
- CMD_ADDR_I  in  IRLENGTH  address to read.
- CMD_ANY_I  in  1  when 1, ignore CMD_ADDR_I and read VALID_ADDRESS_I instead.
- READ_ADDRESS_O  out  IRLENGTH  address presented to the interconnect.
- READ_READY_O  out  1  one-cycle fetch pulse to the interconnect.
- READ_VALID_I  in  1  fetched data is valid.
- READ_DATA_I  in  READ_WIDTH  fetched data.
- VALID_ADDRESS_I  in  IRLENGTH  address of a peripheral that has data ready.
- TX_DATA_O  out  8  byte to the UART TX.
- TX_VALID_O  out  1  TX byte valid.
- TX_READY_I  in  1  UART TX accepts the byte.
- BUSY_O  out  1  high in every state except IDLE.
- TIMEOUT_O  out  1  one-cycle pulse when the retry limit is exhausted.

## Operation
FSM states are IDLE, REQ, CAPTURE and SEND. Transitions:
- IDLE:
  - CMD_READY_O=1.
  - On CMD_VALID_I, latch the address: VALID_ADDRESS_I if CMD_ANY_I=1, else CMD_ADDR_I.
  - Clear the retry counter, then go to REQ.
- REQ:
  - READ_READY_O=1 for exactly this cycle, then go to CAPTURE.
- CAPTURE:
  - Sample READ_VALID_I and READ_DATA_I.
  - If valid, load the shift register with READ_DATA_I and go to SEND.
  - If invalid and retry count < RETRY_LIMIT, increment the count and go to REQ.
  - If invalid and retry count == RETRY_LIMIT, load zeros, pulse TIMEOUT_O and go to SEND.
- SEND:
  - TX_DATA_O = shift_reg[7:0].
  - On TX_VALID_O && TX_READY_I, shift right by 8 and decrement the byte counter.
  - After the last byte is accepted, go to IDLE.
- Frame length is set by the latched address via the package function, clamped to ceil(READ_WIDTH/8):
  - ADDR_DMI: ceil(DMI_WIDTH/8) = 6.
  - ADDR_STB0_CS, ADDR_STB1_CS: 1.
  - ADDR_STB0_D, ADDR_STB1_D, ADDR_IDCODE, ADDR_DTMCS: 4.
  - Any other address: 4.
- Bits of the final byte above READ_WIDTH are sent as 0.
- READ_ADDRESS_O holds the latched address from IDLE exit until the return to IDLE. It is never changed mid-transaction.
- Only one transaction is in flight at a time; new commands wait in IDLE.

## Timing
- Reset values (asserted asynchronously while RST_NI=0): CMD_READY_O=1, READ_READY_O=0, READ_ADDRESS_O=0, TX_DATA_O=0, TX_VALID_O=0, BUSY_O=0, TIMEOUT_O=0. FSM returns to IDLE.
- Reset mid-operation: TX_VALID_O drops immediately and the frame is abandoned. No partial-frame resume.
- Cycle sequence:
  - Accept at cycle 0.
  - READ_READY_O high at cycle 1.
  - Capture at cycle 2; the interconnect registers valid/data one cycle after the ready pulse.
  - TX_VALID_O first high at cycle 3.
- Minimum command-to-first-byte latency is 3 cycles; each retry adds 2 cycles.
- TX handshake:
  - TX_VALID_O stays high and TX_DATA_O stays stable until TX_READY_I.
  - Back-to-back bytes are allowed, 1 per cycle.
- A TX_READY_I held low stalls SEND indefinitely. There is no timeout in SEND.
- CMD_VALID_I while BUSY_O=1 is not accepted; the command must be held by the source.
- CMD_VALID_I and the last byte accept in the same cycle: the command is accepted on the next cycle (IDLE). There is no same-cycle turnaround.

## Configuration
- READ_ARB_HEADER_EN defined:
  - Each frame is preceded by one header byte: the latched address zero-extended to 8 bits.
  - If a timeout occurred, the header byte also has bit 7 set.
  - Frame length is data bytes + 1.
- READ_ARB_HEADER_EN undefined: no header byte; frames carry data bytes only.

## Structure
- uart_pkg gains:
  - function read_frame_bytes(addr) returning a 4-bit byte count.
  - typedef enum read_arb_state_t {IDLE, REQ, CAPTURE, SEND}.
- Existing IRLENGTH and ADDR_* constants are reused from uart_pkg.
- No sub-module: the FSM, retry counter, shift register and byte counter are all in tap_read_arbiter.

## Test plan
- DMI read with READ_VALID_I=1 at the first capture and READ_DATA_I=41'h1_2345_6789_AB, TX_READY_I=1 -> READ_READY_O pulse at cycle 1, then bytes AB,89,67,45,23,01 on cycles 3..8; BUSY_O drops at cycle 9.
- STB0_CS read, status 8'h5A, valid only on the 3rd capture -> 3 READ_READY_O pulses, TIMEOUT_O=0, single byte 5A.
- Peripheral never valid, RETRY_LIMIT=15 -> 16 READ_READY_O pulses, one TIMEOUT_O pulse, 4 zero bytes.
- CMD_ANY_I=1 with VALID_ADDRESS_I=ADDR_STB1_D, data 32'hDEADBEEF -> READ_ADDRESS_O=ADDR_STB1_D throughout; bytes EF,BE,AD,DE.
- TX_READY_I toggled 1/0 every cycle during SEND -> no byte lost or duplicated; TX_DATA_O stable while stalled.
- RST_NI low during the 2nd byte of a DMI frame -> TX_VALID_O=0 immediately; after release CMD_READY_O=1 and the next IDCODE read gives 4 bytes of IDCODEVALUE. With READ_ARB_HEADER_EN, verify the header byte value.

Source files
------------

// File: rtl/uart_pkg.sv
//============================================================================
// Module  : uart_pkg
// Purpose : Shared TAP/UART constants, read-frame sizing and arbiter states.
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

package uart_pkg;

   localparam int IRLENGTH  = 5;
   localparam int DMI_WIDTH = 41;

   localparam logic [IRLENGTH-1:0] ADDR_IDCODE  = 5'h01;
   localparam logic [IRLENGTH-1:0] ADDR_DTMCS   = 5'h10;
   localparam logic [IRLENGTH-1:0] ADDR_DMI     = 5'h11;
   localparam logic [IRLENGTH-1:0] ADDR_STB0_CS = 5'h12;
   localparam logic [IRLENGTH-1:0] ADDR_STB0_D  = 5'h13;
   localparam logic [IRLENGTH-1:0] ADDR_STB1_CS = 5'h14;
   localparam logic [IRLENGTH-1:0] ADDR_STB1_D  = 5'h15;

   localparam logic [31:0] IDCODEVALUE = 32'h1000_0CFD;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      CAPTURE = 2'd2,
      SEND    = 2'd3
   } read_arb_state_t;

   function automatic logic [3:0] read_frame_bytes(input logic [IRLENGTH-1:0] addr);
      logic [3:0] n;
      case (addr)
         ADDR_DMI:                    n = 4'((DMI_WIDTH + 7) / 8);
         ADDR_STB0_CS, ADDR_STB1_CS:  n = 4'd1;
         default:                     n = 4'd4;
      endcase
      return n;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tap_read_arbiter.sv
//============================================================================
// Module  : tap_read_arbiter
// Purpose : Fetches a word over the TAP read interconnect with bounded
//           retries and streams it little-endian to the UART TX.
//           Optional READ_ARB_HEADER_EN prepends an address header byte.
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

module tap_read_arbiter
   import uart_pkg::*;
#(
   parameter int READ_WIDTH  = 41,
   parameter int RETRY_LIMIT = 15
) (
   input  logic                  CLK_I,
   input  logic                  RST_NI,
   input  logic                  CMD_VALID_I,
   output logic                  CMD_READY_O,
   input  logic [IRLENGTH-1:0]   CMD_ADDR_I,
   input  logic                  CMD_ANY_I,
   output logic [IRLENGTH-1:0]   READ_ADDRESS_O,
   output logic                  READ_READY_O,
   input  logic                  READ_VALID_I,
   input  logic [READ_WIDTH-1:0] READ_DATA_I,
   input  logic [IRLENGTH-1:0]   VALID_ADDRESS_I,
   output logic [7:0]            TX_DATA_O,
   output logic                  TX_VALID_O,
   input  logic                  TX_READY_I,
   output logic                  BUSY_O,
   output logic                  TIMEOUT_O
);

   localparam int MAX_BYTES = (READ_WIDTH + 7) / 8;
`ifdef READ_ARB_HEADER_EN
   localparam int HDR_BYTES = 1;
`else
   localparam int HDR_BYTES = 0;
`endif
   localparam int HDR_BITS = HDR_BYTES * 8;
   localparam int SR_W     = (MAX_BYTES + HDR_BYTES) * 8;
   localparam int RETRY_W  = (RETRY_LIMIT < 1) ? 1 : $clog2(RETRY_LIMIT + 1);

   read_arb_state_t      state_q;
   logic [IRLENGTH-1:0]  addr_q;
   logic [RETRY_W-1:0]   retry_q;
   logic [3:0]           byte_cnt_q;
   logic [SR_W-1:0]      shift_q;
   logic                 cmd_ready_q;
   logic                 read_ready_q;
   logic                 tx_valid_q;
   logic                 busy_q;
   logic                 timeout_q;

   logic [IRLENGTH-1:0]  addr_d;
   logic [3:0]           nbytes_d;
   logic [SR_W-1:0]      load_d;

   always_comb begin
      addr_d   = CMD_ANY_I ? VALID_ADDRESS_I : CMD_ADDR_I;
      nbytes_d = read_frame_bytes(addr_d);
      if (int'(nbytes_d) > MAX_BYTES) nbytes_d = 4'(MAX_BYTES);
      nbytes_d = nbytes_d + 4'(HDR_BYTES);
   end

   // An invalid capture only loads the shifter on timeout, so it means a zero frame.
   always_comb begin
      load_d = '0;
      if (READ_VALID_I) load_d[HDR_BITS +: READ_WIDTH] = READ_DATA_I;
`ifdef READ_ARB_HEADER_EN
      load_d[7:0] = 8'(addr_q);
      load_d[7]   = load_d[7] | ~READ_VALID_I;
`endif
   end

   always_ff @(posedge CLK_I or negedge RST_NI) begin
      if (!RST_NI) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         retry_q      <= '0;
         byte_cnt_q   <= '0;
         shift_q      <= '0;
         cmd_ready_q  <= 1'b1;
         read_ready_q <= 1'b0;
         tx_valid_q   <= 1'b0;
         busy_q       <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         read_ready_q <= 1'b0;
         timeout_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (CMD_VALID_I) begin
                  addr_q       <= addr_d;
                  byte_cnt_q   <= nbytes_d;
                  retry_q      <= '0;
                  cmd_ready_q  <= 1'b0;
                  busy_q       <= 1'b1;
                  read_ready_q <= 1'b1;
                  state_q      <= REQ;
               end
            end
            REQ: begin
               state_q <= CAPTURE;
            end
            CAPTURE: begin
               if (READ_VALID_I) begin
                  shift_q    <= load_d;
                  tx_valid_q <= 1'b1;
                  state_q    <= SEND;
               end else if (retry_q < RETRY_W'(RETRY_LIMIT)) begin
                  retry_q      <= retry_q + RETRY_W'(1);
                  read_ready_q <= 1'b1;
                  state_q      <= REQ;
               end else begin
                  shift_q    <= load_d;
                  timeout_q  <= 1'b1;
                  tx_valid_q <= 1'b1;
                  state_q    <= SEND;
               end
            end
            SEND: begin
               if (TX_READY_I) begin
                  shift_q    <= shift_q >> 8;
                  byte_cnt_q <= byte_cnt_q - 4'd1;
                  if (byte_cnt_q == 4'd1) begin
                     tx_valid_q  <= 1'b0;
                     cmd_ready_q <= 1'b1;
                     busy_q      <= 1'b0;
                     state_q     <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign CMD_READY_O    = cmd_ready_q;
   assign READ_ADDRESS_O = addr_q;
   assign READ_READY_O   = read_ready_q;
   assign TX_DATA_O      = shift_q[7:0];
   assign TX_VALID_O     = tx_valid_q;
   assign BUSY_O         = busy_q;
   assign TIMEOUT_O      = timeout_q;

endmodule

`default_nettype wire
